// File: rtl/jlc3_rst_seq.sv
// jlc3_rst_seq: reset/enable sequencer for the jlc3 SoC top level.
// Stretches the power-on reset, releases N_CH reset channels one after the
// other (channel 0 first, STAGGER cycles apart) and gates the core enable in
// free-running or single-step mode once every channel is out of reset.
//
// Optional watchdog: define JLC3_RST_SEQ_WDT_EN to build it in. Without the
// macro kick_i_w is ignored and wdt_flag_o_w is tied low; the port list is the
// same in both builds.
//
//   state  | meaning
//   POR    | all channels held in reset, POR counter running
//   REL    | channels being released one by one
//   RUN    | all channels released, core enable active
module jlc3_rst_seq #(
  parameter int POR_CYCLES = 100,
  parameter int N_CH       = 2,
  parameter int STAGGER    = 8,
  parameter int WDT_CYCLES = 1024
) (
  input  logic            clk_i_w,
  input  logic            rst_i_w,
  input  logic            soft_rst_i_w,
  input  logic            run_i_w,
  input  logic            step_i_w,
  input  logic            kick_i_w,
  output logic [N_CH-1:0] rst_o_w,
  output logic            en_o_w,
  output logic            ready_o_w,
  output logic            wdt_flag_o_w
);

  localparam int POR_W = $clog2(POR_CYCLES + 1);
  localparam int STG_W = $clog2(STAGGER + 1);
  localparam int CH_W  = $clog2(N_CH + 1);

  localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_CYCLES);
  localparam logic [STG_W-1:0] STG_MAX = STG_W'(STAGGER);
  localparam logic [STG_W-1:0] STG_ONE = STG_W'(1);
  localparam logic [CH_W-1:0]  CH_ALL  = CH_W'(N_CH);
  localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);

  typedef enum logic [1:0] {
    ST_POR = 2'd0,
    ST_REL = 2'd1,
    ST_RUN = 2'd2
  } state_t;

  state_t           state_q;
  logic [POR_W-1:0] por_cnt_q;
  logic [STG_W-1:0] stg_cnt_q;
  logic [CH_W-1:0]  ch_cnt_q;
  logic [N_CH-1:0]  rst_q;
  logic             en_q;
  logic             ready_q;
  logic             step_q;
  logic             step_pend_q;
  logic             wdt_fire;
  logic             clear_req;

  // Soft reset and a watchdog expiry both restart the sequence; only the
  // board reset additionally clears the sticky watchdog flag.
  assign clear_req = soft_rst_i_w | wdt_fire;

  // Sequencer FSM with registered channel resets, enable and ready.
  always_ff @(posedge clk_i_w) begin
    if (rst_i_w || clear_req) begin
      state_q     <= ST_POR;
      por_cnt_q   <= '0;
      stg_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      rst_q       <= '1;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q <= step_i_w;
      case (state_q)
        ST_POR: begin
          en_q        <= 1'b0;
          step_pend_q <= 1'b0;
          if (por_cnt_q == POR_MAX) begin
            // Channel 0 leaves reset on the same edge the stretch expires.
            rst_q     <= rst_q << 1;
            ch_cnt_q  <= CH_ONE;
            stg_cnt_q <= STG_ONE;
            state_q   <= ST_REL;
          end else begin
            por_cnt_q <= por_cnt_q + 1'b1;
          end
        end
        ST_REL: begin
          en_q        <= 1'b0;
          step_pend_q <= 1'b0;
          if (ch_cnt_q == CH_ALL) begin
            // One extra cycle after the last release before reporting ready.
            ready_q <= 1'b1;
            state_q <= ST_RUN;
          end else if (stg_cnt_q == STG_MAX) begin
            rst_q     <= rst_q << 1;
            ch_cnt_q  <= ch_cnt_q + 1'b1;
            stg_cnt_q <= STG_ONE;
          end else begin
            stg_cnt_q <= stg_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // A step rising edge is held one cycle in step_pend_q, so the
          // pulse lands on the edge after the one that saw the rise. Steps
          // seen while free-running are dropped.
          en_q        <= run_i_w | step_pend_q;
          step_pend_q <= ~run_i_w & step_i_w & ~step_q;
        end
        default: begin
          state_q <= ST_POR;
          rst_q   <= '1;
          en_q    <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef JLC3_RST_SEQ_WDT_EN
  localparam int               WDT_W   = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES);

  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_flag_q;

  assign wdt_fire = (state_q == ST_RUN) && (wdt_cnt_q == WDT_MAX);

  // Watchdog counter: only runs in RUN, kick clears it, saturates at the limit.
  always_ff @(posedge clk_i_w) begin
    if (rst_i_w || clear_req || (state_q != ST_RUN)) begin
      wdt_cnt_q <= '0;
    end else if (kick_i_w) begin
      wdt_cnt_q <= '0;
    end else if (wdt_cnt_q != WDT_MAX) begin
      wdt_cnt_q <= wdt_cnt_q + 1'b1;
    end
  end

  // Sticky record of a watchdog-triggered restart, cleared by board reset only.
  always_ff @(posedge clk_i_w) begin
    if (rst_i_w) begin
      wdt_flag_q <= 1'b0;
    end else if (wdt_fire) begin
      wdt_flag_q <= 1'b1;
    end
  end

  assign wdt_flag_o_w = wdt_flag_q;
`else
  logic unused_kick;

  assign unused_kick  = kick_i_w;
  assign wdt_fire     = 1'b0;
  assign wdt_flag_o_w = 1'b0;
`endif

  assign rst_o_w   = rst_q;
  assign en_o_w    = en_q;
  assign ready_o_w = ready_q;

endmodule

// File: tb/tb_jlc3_rst_seq.sv
// Bench for jlc3_rst_seq (POR_CYCLES=4, N_CH=3, STAGGER=2, WDT_CYCLES=16).
// Each cycle the expected outputs are derived from a time-since-release model
// and queued; after the edge they are popped and compared with the DUT.
module tb_jlc3_rst_seq;

  localparam int P = 4;
  localparam int N = 3;
  localparam int S = 2;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_i_w = 1'b1;
  logic         soft_rst_i_w = 1'b0;
  logic         run_i_w = 1'b0;
  logic         step_i_w = 1'b0;
  logic         kick_i_w = 1'b0;
  logic [N-1:0] rst_o_w;
  logic         en_o_w;
  logic         ready_o_w;
  logic         wdt_flag_o_w;

  jlc3_rst_seq #(
    .POR_CYCLES (P),
    .N_CH       (N),
    .STAGGER    (S),
    .WDT_CYCLES (W)
  ) dut (
    .clk_i_w      (clk),
    .rst_i_w      (rst_i_w),
    .soft_rst_i_w (soft_rst_i_w),
    .run_i_w      (run_i_w),
    .step_i_w     (step_i_w),
    .kick_i_w     (kick_i_w),
    .rst_o_w      (rst_o_w),
    .en_o_w       (en_o_w),
    .ready_o_w    (ready_o_w),
    .wdt_flag_o_w (wdt_flag_o_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] rst;
    logic         en;
    logic         ready;
    logic         flag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulse_cnt = 0;

  // Model state: m_k counts edges since release (-1 while held in reset).
  int   m_k = -1;
  logic m_en = 1'b0, m_pend = 1'b0, m_step_prev = 1'b0, m_ready = 1'b0, m_flag = 1'b0;
  int   m_wdt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the model's prediction, compare after the edge.
  task automatic cyc(input logic r, input logic s, input logic rn, input logic st, input logic kk);
    exp_t e;
    exp_t g;
    logic fire;
    logic new_en;
    logic new_pend;
    rst_i_w      = r;
    soft_rst_i_w = s;
    run_i_w      = rn;
    step_i_w     = st;
    kick_i_w     = kk;
    fire = 1'b0;
`ifdef JLC3_RST_SEQ_WDT_EN
    fire = m_ready && (m_wdt == W);
`endif
    if (r || s || fire) begin
      m_k = -1;
      m_en = 1'b0;
      m_pend = 1'b0;
      m_step_prev = 1'b0;
      m_wdt = 0;
      m_ready = 1'b0;
      if (r) m_flag = 1'b0;
      else if (fire) m_flag = 1'b1;
    end else begin
      new_en   = m_ready && (rn || m_pend);
      new_pend = m_ready && !rn && st && !m_step_prev;
      if (!m_ready) m_wdt = 0;
      else if (kk) m_wdt = 0;
      else if (m_wdt < W) m_wdt = m_wdt + 1;
      m_en = new_en;
      m_pend = new_pend;
      m_step_prev = st;
      if (m_k < 1000000) m_k = m_k + 1;
      m_ready = (m_k >= P + (N - 1) * S + 1);
    end
    for (int c = 0; c < N; c++) e.rst[c] = (m_k < P + c * S);
    e.en = m_en;
    e.ready = m_ready;
    e.flag = m_flag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk("rst_o", 32'(rst_o_w), 32'(g.rst));
    chk("en_o", 32'(en_o_w), 32'(g.en));
    chk("ready_o", 32'(ready_o_w), 32'(g.ready));
    chk("wdt_flag", 32'(wdt_flag_o_w), 32'(g.flag));
    if (en_o_w) pulse_cnt++;
  endtask

  task automatic wait_ready(input int budget, input logic rn);
    int n;
    n = 0;
    while (!ready_o_w && n < budget) begin
      cyc(1'b0, 1'b0, rn, 1'b0, 1'b0);
      n++;
    end
    chk("ready_timeout", 32'(ready_o_w), 32'd1);
  endtask

  function automatic logic [N-1:0] rel_vec(input int k);
    if (k < 4) return 3'b111;
    else if (k < 6) return 3'b110;
    else if (k < 8) return 3'b100;
    else return 3'b000;
  endfunction

  initial begin
    // 1: board reset, staggered release with literal expectations
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_reset_rst", 32'(rst_o_w), 32'h7);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t1_rst_k%0d", k), 32'(rst_o_w), 32'(rel_vec(k)));
      chk($sformatf("t1_rdy_k%0d", k), 32'(ready_o_w), (k >= 9) ? 32'd1 : 32'd0);
    end

    // 2: free-running enable follows run with one cycle of latency
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_en_on", 32'(en_o_w), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_en_off", 32'(en_o_w), 32'd0);

    // 3: step held high yields one pulse, a second rise another
    pulse_cnt = 0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_one_pulse", 32'(pulse_cnt), 32'd1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_two_pulses", 32'(pulse_cnt), 32'd2);
    // steps while free-running are discarded
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_run_step_drop", 32'(en_o_w), 32'd0);

    // 4: soft reset mid-release, steps during release ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_pre_soft", 32'(rst_o_w), 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_soft_rst", 32'(rst_o_w), 32'h7);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'(k % 2), 1'b0);
      chk($sformatf("t4_rst_k%0d", k), 32'(rst_o_w), 32'(rel_vec(k)));
    end
    // held soft reset keeps POR counter at zero
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t4h_rst_k%0d", k), 32'(rst_o_w), 32'(rel_vec(k)));
    end

    // 5: board reset during a step pulse
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_pulse", 32'(en_o_w), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_en", 32'(en_o_w), 32'd0);
    chk("t5_rst", 32'(rst_o_w), 32'h7);
    chk("t5_ready", 32'(ready_o_w), 32'd0);

    // 6: watchdog
    wait_ready(40, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef JLC3_RST_SEQ_WDT_EN
    chk("t6_flag_set", 32'(wdt_flag_o_w), 32'd1);
    wait_ready(40, 1'b1);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'((i % 10) == 9));
    chk("t6_kick_no_rst", 32'(rst_o_w), 32'h0);
    chk("t6_flag_sticky", 32'(wdt_flag_o_w), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_flag_clear", 32'(wdt_flag_o_w), 32'd0);
`else
    chk("t6_no_wdt_flag", 32'(wdt_flag_o_w), 32'd0);
    chk("t6_no_wdt_rst", 32'(rst_o_w), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // 7: random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 3),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
